cordic_req_sched: RTL



---
 rtl/cordic_req_sched.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/cordic_req_sched.sv
// Round-robin scheduler sharing one fixed-latency CORDIC sin/cos pipeline among NUM_REQ clients.
// Define QUAD_FOLD_EN to fold quadrants 1/2 onto 3/0 on issue and negate the results on return.
module cordic_req_sched #(
    parameter int NUM_REQ  = 4,
    parameter int PIPE_LAT = 16,
    parameter int ID_W     = 2
) (
    input  logic                  Clk_i,
    input  logic                  Rst_i,
    input  logic [NUM_REQ-1:0]    Req_Valid_i,
    input  logic [16*NUM_REQ-1:0] Req_Angle_i,
    output logic [NUM_REQ-1:0]    Req_Ready_o,
    input  logic                  Flush_i,
    output logic                  Pipe_Start_o,
    output logic [15:0]           Pipe_Angle_o,
    input  logic                  Pipe_Done_i,
    input  logic [15:0]           Pipe_Sin_i,
    input  logic [15:0]           Pipe_Cos_i,
    output logic [NUM_REQ-1:0]    Rsp_Valid_o,
    output logic [ID_W-1:0]       Rsp_Id_o,
    output logic [15:0]           Rsp_Sin_o,
    output logic [15:0]           Rsp_Cos_o,
    output logic                  Busy_o,
    output logic                  Err_o
);

    logic [ID_W-1:0]    rr_ptr;
    logic [NUM_REQ-1:0] upper;
    logic [NUM_REQ-1:0] pick;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic [15:0]        sel_angle;
    logic [15:0]        issue_angle;
    logic               xfer;

    logic [PIPE_LAT:0]  live;
    logic [PIPE_LAT:0]  issued;
    logic [PIPE_LAT:0]  shadow;
    logic [ID_W-1:0]    tag_id [PIPE_LAT+1];

    logic               rsp_fire;
    logic               proto_err;
    logic [15:0]        sin_out;
    logic [15:0]        cos_out;

`ifdef QUAD_FOLD_EN
    logic               issue_fold;
    logic [PIPE_LAT:0]  fold_bits;

    function automatic logic [15:0] sat_neg(input logic [15:0] v);
        return (v == 16'h8000) ? 16'h7fff : (~v + 16'd1);
    endfunction
`endif

    // Requesters at or after the pointer win first; otherwise wrap to the lowest valid index.
    always_comb begin
        upper = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            upper[i] = Req_Valid_i[i] && (ID_W'(i) >= rr_ptr);
        end
        pick  = (|upper) ? upper : Req_Valid_i;
        grant = pick & (~pick + NUM_REQ'(1));
        if (Rst_i || Flush_i) begin
            grant = '0;
        end
    end

    always_comb begin
        grant_id  = '0;
        sel_angle = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_id  = ID_W'(i);
                sel_angle = Req_Angle_i[16*i +: 16];
            end
        end
    end

    assign xfer        = |grant;
    assign Req_Ready_o = grant;

`ifdef QUAD_FOLD_EN
    // Adding 0x8000 only flips the MSB, mapping quadrants 1/2 onto 3/0.
    always_comb begin
        issue_fold  = sel_angle[15] ^ sel_angle[14];
        issue_angle = issue_fold ? {~sel_angle[15], sel_angle[14:0]} : sel_angle;
    end
`else
    assign issue_angle = sel_angle;
`endif

    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            rr_ptr       <= '0;
            Pipe_Start_o <= 1'b0;
            Pipe_Angle_o <= '0;
        end else begin
            Pipe_Start_o <= xfer;
            if (xfer) begin
                Pipe_Angle_o <= issue_angle;
                rr_ptr       <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
            end
        end
    end

    // Shadow bits remember operations issued before a reset so their late Done pulses are tolerated.
    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            live   <= '0;
            issued <= '0;
            shadow <= {shadow[PIPE_LAT-1:0] | issued[PIPE_LAT-1:0], 1'b0};
        end else begin
            live   <= Flush_i ? '0 : {live[PIPE_LAT-1:0], xfer};
            issued <= {issued[PIPE_LAT-1:0], xfer};
            shadow <= {shadow[PIPE_LAT-1:0], 1'b0};
        end
    end

    always_ff @(posedge Clk_i) begin
        tag_id[0] <= grant_id;
        for (int s = 1; s <= PIPE_LAT; s++) begin
            tag_id[s] <= tag_id[s-1];
        end
    end

`ifdef QUAD_FOLD_EN
    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            fold_bits <= '0;
        end else begin
            fold_bits <= {fold_bits[PIPE_LAT-1:0], xfer & issue_fold};
        end
    end

    assign sin_out = fold_bits[PIPE_LAT] ? sat_neg(Pipe_Sin_i) : Pipe_Sin_i;
    assign cos_out = fold_bits[PIPE_LAT] ? sat_neg(Pipe_Cos_i) : Pipe_Cos_i;
`else
    assign sin_out = Pipe_Sin_i;
    assign cos_out = Pipe_Cos_i;
`endif

    assign rsp_fire  = live[PIPE_LAT] && Pipe_Done_i && !Flush_i;
    assign proto_err = !shadow[PIPE_LAT] && (Pipe_Done_i != issued[PIPE_LAT]);

    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            Rsp_Valid_o <= '0;
            Rsp_Id_o    <= '0;
            Rsp_Sin_o   <= '0;
            Rsp_Cos_o   <= '0;
        end else begin
            Rsp_Valid_o <= rsp_fire ? (NUM_REQ'(1) << tag_id[PIPE_LAT]) : '0;
            if (rsp_fire) begin
                Rsp_Id_o  <= tag_id[PIPE_LAT];
                Rsp_Sin_o <= sin_out;
                Rsp_Cos_o <= cos_out;
            end
        end
    end

    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            Err_o <= 1'b0;
        end else if (proto_err) begin
            Err_o <= 1'b1;
        end
    end

    assign Busy_o = (|live) | Pipe_Start_o;

endmodule
